// File: rtl/march_bist_if.sv
// March BIST controller bus: wrapper handshake (start/result) plus the SRAM
// port-mux side. The controller takes the master modport; the wrapper/SRAM
// side takes the slave modport.
interface march_bist_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4
) ();
    logic              start;
    logic              sram_en;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ADDR_W-1:0] fail_addr;
    logic [2:0]        fail_elem;
    logic [DATA_W-1:0] fail_data;
    logic [7:0]        fail_count;

    modport master (
        input  start, sram_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata,
        output busy, done, pass, fail_addr, fail_elem, fail_data, fail_count
    );

    modport slave (
        output start, sram_rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata,
        input  busy, done, pass, fail_addr, fail_elem, fail_data, fail_count
    );
endinterface

// File: rtl/march_bist_ctrl.sv
// March C- BIST sequencer for a single-port synchronous SRAM.
// Issues one op per cycle over elements M0..M5, compares each read one cycle
// later, and records first-failure info plus a saturating failure count.
// Optional build macro BIST_STOP_ON_FAIL_EN: end the test on the first mismatch.
module march_bist_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    march_bist_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
    localparam logic [2:0]        LAST_ELEM = 3'd5;

    state_e            state_q, state_d;
    logic              en_q, en_d, we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        elem_q, elem_d;
    logic              op_q, op_d;          // 0 = first op at this address, 1 = second
    logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]        fail_elem_q, fail_elem_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d;
    logic [7:0]        fail_count_q, fail_count_d;
    logic              cmp_valid_q, cmp_valid_d;
    logic [DATA_W-1:0] cmp_exp_q, cmp_exp_d;
    logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
    logic [2:0]        cmp_elem_q, cmp_elem_d;

    logic       mismatch, stop_req, last_op, last_addr;
    logic [2:0] nxt_elem;

    // Descending elements are M3 and M4.
    function automatic logic elem_down(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    // Only M0 starts with a write; every second op is a write.
    function automatic logic op_is_write(input logic [2:0] e, input logic op);
        return (e == 3'd0) || op;
    endfunction

    // Background bit: read value for the first op, write value for the second.
    // For reads the driven wdata doubles as the expected data.
    function automatic logic op_bg(input logic [2:0] e, input logic op);
        return op ? ((e == 3'd1) || (e == 3'd3)) : ((e == 3'd2) || (e == 3'd4));
    endfunction

    assign mismatch  = cmp_valid_q && (state_q == S_RUN || state_q == S_DRAIN)
                       && (bus.sram_rdata != cmp_exp_q);
    assign last_op   = op_q || (elem_q == 3'd0) || (elem_q == LAST_ELEM);
    assign last_addr = elem_down(elem_q) ? (addr_q == '0) : (addr_q == ADDR_MAX);
    assign nxt_elem  = elem_q + 3'd1;

`ifdef BIST_STOP_ON_FAIL_EN
    assign stop_req = mismatch;
`else
    assign stop_req = 1'b0;
`endif

    // Next-state, next-op and failure-capture logic.
    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_d      = state_q;
        en_d         = 1'b0;
        we_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        elem_d       = elem_q;
        op_d         = op_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        fail_addr_d  = fail_addr_q;
        fail_elem_d  = fail_elem_q;
        fail_data_d  = fail_data_q;
        fail_count_d = fail_count_q;
        cmp_valid_d  = en_q && !we_q;
        cmp_exp_d    = wdata_q;
        cmp_addr_d   = addr_q;
        cmp_elem_d   = elem_q;

        if (mismatch) begin
            if (fail_count_q != 8'hFF) fail_count_d = fail_count_q + 8'd1;
            if (fail_count_q == 8'd0) begin
                fail_addr_d = cmp_addr_q;
                fail_elem_d = cmp_elem_q;
                fail_data_d = bus.sram_rdata;
            end
        end

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d      = S_RUN;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    fail_addr_d  = '0;
                    fail_elem_d  = '0;
                    fail_data_d  = '0;
                    fail_count_d = '0;
                    en_d         = 1'b1;
                    we_d         = 1'b1;
                    addr_d       = '0;
                    wdata_d      = '0;
                    elem_d       = 3'd0;
                    op_d         = 1'b0;
                end
            end
            S_RUN: begin
                if (stop_req) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = 1'b0;
                end else if (!last_op) begin
                    en_d    = 1'b1;
                    op_d    = 1'b1;
                    we_d    = op_is_write(elem_q, 1'b1);
                    wdata_d = {DATA_W{op_bg(elem_q, 1'b1)}};
                end else if (!last_addr) begin
                    en_d    = 1'b1;
                    op_d    = 1'b0;
                    addr_d  = elem_down(elem_q) ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
                    we_d    = op_is_write(elem_q, 1'b0);
                    wdata_d = {DATA_W{op_bg(elem_q, 1'b0)}};
                end else if (elem_q == LAST_ELEM) begin
                    state_d = S_DRAIN;
                end else begin
                    en_d    = 1'b1;
                    op_d    = 1'b0;
                    elem_d  = nxt_elem;
                    addr_d  = elem_down(nxt_elem) ? ADDR_MAX : '0;
                    we_d    = op_is_write(nxt_elem, 1'b0);
                    wdata_d = {DATA_W{op_bg(nxt_elem, 1'b0)}};
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (fail_count_d == 8'd0);
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; synchronous reset aborts any run at once.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment only.
        if (rst) begin
            state_q      <= S_IDLE;
            en_q         <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            elem_q       <= 3'd0;
            op_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_addr_q  <= '0;
            fail_elem_q  <= 3'd0;
            fail_data_q  <= '0;
            fail_count_q <= 8'd0;
            cmp_valid_q  <= 1'b0;
            cmp_exp_q    <= '0;
            cmp_addr_q   <= '0;
            cmp_elem_q   <= 3'd0;
        end else begin
            state_q      <= state_d;
            en_q         <= en_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            elem_q       <= elem_d;
            op_q         <= op_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_addr_q  <= fail_addr_d;
            fail_elem_q  <= fail_elem_d;
            fail_data_q  <= fail_data_d;
            fail_count_q <= fail_count_d;
            cmp_valid_q  <= cmp_valid_d;
            cmp_exp_q    <= cmp_exp_d;
            cmp_addr_q   <= cmp_addr_d;
            cmp_elem_q   <= cmp_elem_d;
        end
    end

    assign bus.sram_en    = en_q;
    assign bus.sram_we    = we_q;
    assign bus.sram_addr  = addr_q;
    assign bus.sram_wdata = wdata_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.fail_addr  = fail_addr_q;
    assign bus.fail_elem  = fail_elem_q;
    assign bus.fail_data  = fail_data_q;
    assign bus.fail_count = fail_count_q;
endmodule

// File: doc/march_bist_ctrl.md
Name: march_bist_ctrl

Overview:
- March C- BIST sequencer for the 256x4b single-port synchronous SRAM.
- Generates address, read/write enable, write background and expected data for all six march elements, and compares read data one cycle after each read.
- Captures first-failure info and a failure count; reports done/pass to the top-level BIST wrapper.
- Sits between the BIST wrapper (start/result) and the SRAM port mux.

Parameters:
- ADDR_W, 8, SRAM address width (depth = 2**ADDR_W).
- DATA_W, 4, SRAM word width; backgrounds are all-0 / all-1 replicated to DATA_W.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin test; sampled only in IDLE or DONE.
- sram_en  out  1  SRAM access enable (registered).
- sram_we  out  1  1=write, 0=read (registered).
- sram_addr  out  ADDR_W  SRAM address (registered).
- sram_wdata  out  DATA_W  write data (registered).
- sram_rdata  in  DATA_W  read data, valid the cycle after a read is issued.
- busy  out  1  test in progress.
- done  out  1  test finished; held until next start or rst.
- pass  out  1  valid when done=1; 1 = no mismatch.
- fail_addr  out  ADDR_W  address of first mismatch.
- fail_elem  out  3  element index (0-5) of first mismatch.
- fail_data  out  DATA_W  read data observed at first mismatch.
- fail_count  out  8  mismatches seen, saturating at 255.

Behaviour:
- Reset: sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0, busy=0, done=0, pass=0, fail_addr=0, fail_elem=0, fail_data=0, fail_count=0, state IDLE. rst mid-test aborts immediately, with no further SRAM access.
- States: IDLE -> RUN on start. RUN -> DRAIN after the last op of M5. DRAIN (1 cycle, final compare) -> DONE. DONE -> RUN on start, which clears the fail regs, done and pass. start while busy is ignored.
- Elements, where E = element index, 0/1 = all-0/all-1 data:
  - M0 up: w0.
  - M1 up: r0, w1.
  - M2 up: r1, w0.
  - M3 down: r0, w1.
  - M4 down: r1, w0.
  - M5 up: r0.
- Up elements go 0x00 -> 0xFF; down elements go 0xFF -> 0x00.
- Per address, the element's ops are issued on consecutive cycles, one op per cycle, with no idle cycles between addresses or elements. Total 10*256 = 2560 op cycles.
- Timing: start sampled at edge 0; ops drive cycles 1..2560; DRAIN in cycle 2561; done=1 and busy=0 from cycle 2562.
- busy=1 from cycle 1 through DRAIN.
- Compare pipeline:
  - A read issued in cycle t registers the expected value, address and element.
  - In cycle t+1, sram_rdata is compared against the expected value.
  - On mismatch: fail_count increments (saturating at 255).
  - If it is the first mismatch, fail_addr, fail_elem and fail_data are captured.
- Address counter wraps inside the element; the element boundary is detected at 0xFF (up) or 0x00 (down). Counter is ADDR_W bits, with no carry into sram_addr.
- pass = (fail_count==0), registered on entry to DONE.
- sram_en=0 in IDLE, DRAIN and DONE.

Optional Feature:
- Macro: BIST_STOP_ON_FAIL_EN.
- Defined:
  - On the first mismatch, the FSM goes to DONE on the next edge, with pass=0.
  - At most one SRAM op (the one issued in the compare cycle) follows the failing read.
  - fail_count = 1.
- Undefined: the test always runs all 2560 ops and counts every mismatch.

Test Plan:
- Fault-free SRAM model, start pulse -> done=1 in cycle 2562 after start edge; pass=1, fail_count=0; sram_addr sequence checked for all 6 elements, including the descending M3/M4 order.
- Bit 2 of addr 0x37 stuck-at-0 -> fail_elem=2, fail_addr=0x37, fail_data=4'b1011, fail_count=2 (M2, M4); pass=0.
- Bit 0 of addr 0xFF stuck-at-1 -> fail_elem=1, fail_addr=0xFF, fail_data=4'b0001, fail_count=3 (M1, M3, M5).
- rst asserted in cycle 1000 of a run -> next cycle all outputs at reset values, sram_en=0. A new start then completes in 2562 cycles with pass=1.
- start pulsed at cycles 5 and 2000 while busy -> ignored, completion still at cycle 2562. start in DONE -> fail regs cleared, new run begins.
- With BIST_STOP_ON_FAIL_EN, bit 1 of addr 0x00 stuck-at-1 -> M1 read of 0x00 issued in cycle 257, mismatch in cycle 258, done=1 in cycle 259; fail_elem=1, fail_count=1.
